wb_host_bridge: RTL and testbench

//   Wishbone classic single-beat bus initiator. Turns a valid/ready command stream
//   (from a test sequencer, LA-driven host or management shim) into Wishbone read/write

---
 rtl/wb_host_bridge.sv | 113 +++++++++++
 tb/tb_wb_host_bridge.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wb_host_bridge.sv
// wb_host_bridge: Wishbone classic single-beat initiator driven by a valid/ready command stream
module wb_host_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [ADDR_W-1:0]   cmd_adr_i,
    input  logic [DATA_W-1:0]   cmd_dat_i,
    input  logic [DATA_W/8-1:0] cmd_sel_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_dat_o,
    output logic                rsp_err_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    output logic                busy_o,
    output logic [7:0]          err_cnt_o
);
    localparam int SEL_W = DATA_W / 8;
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [WD_W-1:0]   r_wd;
    logic [7:0]        r_err_cnt;
    logic              r_cyc;
    logic              r_we;
    logic [SEL_W-1:0]  r_sel;
    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_dat;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_dat;
    logic              r_rsp_err;
    logic              w_expire;

    // Watchdog hits its limit on the TIMEOUT-th cycle the strobe has been held
    assign w_expire    = (TIMEOUT != 0) && (r_wd == WD_W'(TIMEOUT - 1));
    assign cmd_ready_o = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE);
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign err_cnt_o   = r_err_cnt;

    // Command -> bus cycle -> response sequencer with watchdog and error counter
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= S_IDLE;
            r_wd        <= '0;
            r_err_cnt   <= '0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (cmd_valid_i) begin
                    r_we    <= cmd_we_i;
                    r_sel   <= cmd_sel_i;
                    r_adr   <= {cmd_adr_i[ADDR_W-1:2], 2'b00};
                    r_dat   <= cmd_dat_i;
                    r_cyc   <= 1'b1;
                    r_wd    <= '0;
                    r_state <= S_BUS;
                end
                S_BUS: if (wbm_ack_i) begin
                    r_cyc       <= 1'b0;
                    r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end else if (w_expire) begin
                    r_cyc       <= 1'b0;
                    r_rsp_dat   <= '0;
                    r_rsp_err   <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_err_cnt   <= (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
                    r_state     <= S_RESP;
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
                S_RESP: if (rsp_ready_i) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_host_bridge.sv
// tb_wb_host_bridge: directed and randomized checks of wb_host_bridge against a transaction-level model
module tb_wb_host_bridge;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat = '0;
    logic        busy;
    logic [7:0]  err_cnt;

    int vectors = 0;
    int miscompares = 0;
    int wait_n = 0;
    int stb_cnt = 0;
    logic spur = 1'b0;
    int model_err = 0;

    wb_host_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_ack_i(ack), .wbm_dat_i(rdat),
        .busy_o(busy), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    // Slave: acks in the (wait_n+1)-th cycle of a strobe; spur injects stray acks outside a cycle
    assign ack = stb ? (stb_cnt == wait_n) : spur;
    always @(posedge clk or negedge rst_n)
        if (!rst_n || !stb) stb_cnt <= 0;
        else stb_cnt <= stb_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction: issue, watch the strobe, check the response, release after bp stall cycles
    task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int wt, input logic [31:0] rd, input int bp);
        logic        exp_err;
        int          n;
        logic [31:0] held_dat;
        logic        held_err;
        exp_err = (wt >= TO);
        wait_n = wt;
        rdat = rd;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!stb) break;
            n++;
            if (n == 1) begin
                check("wbm_adr", adr, {a[31:2], 2'b00});
                check("wbm_we", we, w);
                check("wbm_dat", wdat, d);
                check("wbm_sel", sel, s);
                check("cyc_eq_stb", cyc, 1);
                check("busy", busy, 1);
                check("cmd_ready_bus", cmd_ready, 0);
            end
        end
        if (exp_err && model_err < 255) model_err++;
        check("stb_len", n, exp_err ? TO : wt + 1);
        check("cyc_off", cyc, 0);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_dat", rsp_dat, (exp_err || w) ? 32'h0 : rd);
        check("err_cnt", err_cnt, model_err);
        held_dat = rsp_dat;
        held_err = rsp_err;
        for (int k = 0; k < bp; k++) begin
            cmd_valid = 1'b1;
            cmd_adr = $urandom;
            spur = 1'($urandom);
            @(negedge clk);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_dat", rsp_dat, held_dat);
            check("bp_rsp_err", rsp_err, held_err);
            check("bp_stb", stb, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0; cmd_valid = 1'b0; spur = 1'b0;
        @(negedge clk);
        check("rsp_consumed", rsp_valid, 0);
        check("cmd_ready_back", cmd_ready, 1);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        #2;
        check("rst_cyc", cyc, 0);
        check("rst_stb", stb, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_adr", adr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("cmd_ready_rst", cmd_ready, 1);

        // Directed: write with immediate ack, read with 3 wait states
        do_cmd(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, 0, 32'h1234_5678, 0);
        do_cmd(1'b0, 32'h3000_0003, 32'h0, 4'hF, 3, 32'h0000_0042, 0);
        // Timeout, then ack exactly on the expiry cycle
        do_cmd(1'b0, 32'h3000_0010, 32'h0, 4'h3, 100, 32'hAAAA_5555, 0);
        do_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hF, TO - 1, 32'hCAFE_F00D, 0);
        // Back-pressure with a command held for 10 cycles
        do_cmd(1'b1, 32'h3000_0020, 32'h0BAD_F00D, 4'h5, 2, 32'h0, 10);

        // Stray acks while idle must not disturb anything
        spur = 1'b1;
        repeat (3) @(negedge clk);
        spur = 1'b0;
        check("spur_rsp_valid", rsp_valid, 0);
        check("spur_stb", stb, 0);
        check("spur_err_cnt", err_cnt, model_err);

        // Randomized traffic
        for (int i = 0; i < 60; i++)
            do_cmd(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, TO + 2),
                   $urandom, $urandom_range(0, 3));

        // Saturating error counter
        for (int i = 0; i < 300; i++)
            do_cmd(1'b0, $urandom, 32'h0, 4'hF, 1000, $urandom, 0);
        check("err_cnt_sat", err_cnt, 255);

        // Asynchronous reset in the middle of a bus cycle
        wait_n = 1000;
        @(negedge clk);
        cmd_we = 1'b1; cmd_adr = 32'h3000_0040; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_stb", stb, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_cyc", cyc, 0);
        check("async_stb", stb, 0);
        check("async_rsp", rsp_valid, 0);
        model_err = 0;
        check("async_err_cnt", err_cnt, model_err);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_ready", cmd_ready, 1);
            check("post_rst_rsp", rsp_valid, 0);
            check("post_rst_stb", stb, 0);
        end
        do_cmd(1'b0, 32'h3000_0044, 32'h0, 4'hF, 1, 32'h7777_0001, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
